rv_wb_mem_ctrl: RTL and testbench

RV_WB_MEM_CTRL -- requirements
Module: rv_wb_mem_ctrl

---
 rtl/rv_wb_mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_rv_wb_mem_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_wb_mem_ctrl.sv
// Purpose : Wishbone classic slave bridging a 32-bit core bus onto a single-port
//           synchronous SRAM window at BASE_ADDR; out-of-window accesses get err.
// Latency : request sampled at edge T -> ack in cycle T+2+WAIT_STATES, err in T+1.
// Backpr. : one access in flight; stb is ignored until IDLE, and IDLE lasts >=1
//           cycle between responses. Dropping cyc in ACCESS/WAIT aborts (no ack).
// Ports   : i_clk/i_reset_n (sync, active-low); i_wb_* / o_wb_* Wishbone slave;
//           o_mem_* SRAM command (word address, data, byte enables, en, we);
//           i_mem_rdata SRAM read data, valid the cycle after a read enable.
module rv_wb_mem_ctrl #(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [31:0]       i_wb_adr,
  input  logic [31:0]       i_wb_dat,
  output logic [31:0]       o_wb_dat,
  input  logic              i_wb_we,
  input  logic [3:0]        i_wb_sel,
  input  logic              i_wb_stb,
  input  logic              i_wb_cyc,
  output logic              o_wb_ack,
  output logic              o_wb_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  output logic              o_mem_en,
  output logic              o_mem_we,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  // Bits above the SRAM window must match the base address.
  localparam logic [31:0] WIN_MASK  = ~((32'h1 << (ADDR_W + 2)) - 32'h1);
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'h0;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        req_we;
  logic        rd_first;   // high on the cycle the SRAM read data is valid
  logic [31:0] rd_buf;     // read data held across wait states
  logic        in_window;

  assign in_window = ((i_wb_adr ^ BASE_ADDR) & WIN_MASK) == 32'h0;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'h0;
      req_we      <= 1'b0;
      rd_first    <= 1'b0;
      rd_buf      <= 32'h0;
      o_wb_dat    <= 32'h0;
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= 32'h0;
      o_mem_be    <= 4'h0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      rd_first <= 1'b0;
      if (rd_first) begin
        rd_buf <= i_mem_rdata;
      end

      case (state)
        S_IDLE: begin
          if (i_wb_stb && i_wb_cyc) begin
            req_we <= i_wb_we;
            if (in_window) begin
              o_mem_addr  <= i_wb_adr[ADDR_W+1:2];
              o_mem_wdata <= i_wb_dat;
              o_mem_en    <= 1'b1;
              o_mem_we    <= i_wb_we;
              // Reads always fetch the full word; lanes are picked by the core.
              o_mem_be    <= i_wb_we ? i_wb_sel : 4'hF;
              state       <= S_ACCESS;
            end else begin
              state <= S_ERR;
            end
          end
        end

        S_ACCESS: begin
          o_mem_en <= 1'b0;
          o_mem_we <= 1'b0;
          o_mem_be <= 4'h0;
          if (!i_wb_cyc) begin
            state <= S_IDLE;
          end else if (WAIT_STATES > 0) begin
            wait_cnt <= WAIT_INIT;
            rd_first <= 1'b1;
            state    <= S_WAIT;
          end else begin
            rd_first <= 1'b1;
            state    <= S_RESP;
          end
        end

        S_WAIT: begin
          if (!i_wb_cyc) begin
            wait_cnt <= 4'h0;
            state    <= S_IDLE;
          end else if (wait_cnt == 4'h0) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'h1;
          end
        end

        S_RESP: begin
          o_wb_ack <= 1'b1;
          if (!req_we) begin
            // With no wait states the data is still on the SRAM bus.
            o_wb_dat <= rd_first ? i_mem_rdata : rd_buf;
          end
          state <= S_IDLE;
        end

        S_ERR: begin
          o_wb_err <= 1'b1;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_wb_mem_ctrl.sv
// Purpose : scoreboard bench for rv_wb_mem_ctrl; three instances with
//           WAIT_STATES 0, 3 and 2, each with its own behavioural SRAM.
// Latency : expected response cycle is pushed with each request.
// Backpr. : the master holds stb/cyc until ack/err, bounded by a cycle budget.
module tb_rv_wb_mem_ctrl;

  localparam int N = 3;

  typedef struct {
    int          d;
    bit          is_err;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc_cnt = 0;
  int          n_total = 0;
  int          n_pass = 0;

  logic        rst_n     [N];
  logic [31:0] wb_adr    [N];
  logic [31:0] wb_wdat   [N];
  logic [31:0] wb_rdat   [N];
  logic        wb_we     [N];
  logic [3:0]  wb_sel    [N];
  logic        wb_stb    [N];
  logic        wb_cyc    [N];
  logic        wb_ack    [N];
  logic        wb_err    [N];
  logic [11:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [3:0]  mem_be    [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [31:0] mem_rdata [N];

  logic [31:0] sram      [N][64];
  int          en_cnt    [N];
  int          resp_cnt  [N];
  logic [11:0] last_addr [N];
  logic        last_we   [N];
  logic [3:0]  last_be   [N];
  logic [31:0] last_wdat [N];
  logic [31:0] exp_dat   [N];

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    rv_wb_mem_ctrl #(
      .ADDR_W     (12),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n[g]),
      .i_wb_adr   (wb_adr[g]),
      .i_wb_dat   (wb_wdat[g]),
      .o_wb_dat   (wb_rdat[g]),
      .i_wb_we    (wb_we[g]),
      .i_wb_sel   (wb_sel[g]),
      .i_wb_stb   (wb_stb[g]),
      .i_wb_cyc   (wb_cyc[g]),
      .o_wb_ack   (wb_ack[g]),
      .o_wb_err   (wb_err[g]),
      .o_mem_addr (mem_addr[g]),
      .o_mem_wdata(mem_wdata[g]),
      .o_mem_be   (mem_be[g]),
      .o_mem_en   (mem_en[g]),
      .o_mem_we   (mem_we[g]),
      .i_mem_rdata(mem_rdata[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, got, expv);
  endtask

  // Behavioural SRAM: read data valid only the cycle after a read enable.
  always @(posedge clk) begin
    for (int d = 0; d < N; d++) begin
      mem_rdata[d] <= 32'h0BAD_F00D;
      if (mem_en[d] === 1'b1) begin
        en_cnt[d]    <= en_cnt[d] + 1;
        last_addr[d] <= mem_addr[d];
        last_we[d]   <= mem_we[d];
        last_be[d]   <= mem_be[d];
        last_wdat[d] <= mem_wdata[d];
        if (mem_we[d]) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[d][b]) sram[d][mem_addr[d][5:0]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
        end else begin
          mem_rdata[d] <= sram[d][mem_addr[d][5:0]];
        end
      end
    end
  end

  // Monitor: every ack/err is matched against the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int d = 0; d < N; d++) begin
      if (wb_ack[d] === 1'b1 || wb_err[d] === 1'b1) begin
        resp_cnt[d] = resp_cnt[d] + 1;
        chk("ack_err_excl", wb_ack[d] & wb_err[d], 0);
        if (sb.size() == 0) begin
          chk("unexpected_resp", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("resp_dut", d, e.d);
          chk("resp_kind_err", wb_err[d], e.is_err);
          chk("resp_cycle", cyc_cnt, e.cyc);
          chk("resp_dat", wb_rdat[d], e.dat);
        end
      end
    end
  end

  // Issue one request (stb left high on return) and wait for its response.
  task automatic xfer(input int d, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] rexp, input bit is_err);
    exp_t e;
    bit   done;
    wb_adr[d]  = adr;
    wb_wdat[d] = dat;
    wb_we[d]   = we;
    wb_sel[d]  = sel;
    wb_stb[d]  = 1'b1;
    wb_cyc[d]  = 1'b1;
    if (!is_err && !we) exp_dat[d] = rexp;
    e.d      = d;
    e.is_err = is_err;
    e.dat    = exp_dat[d];
    e.cyc    = cyc_cnt + 1 + (is_err ? 1 : 2 + ws_of(d));
    sb.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (wb_ack[d] === 1'b1 || wb_err[d] === 1'b1) done = 1'b1;
    end
    if (!done) chk("resp_timeout", done, 1);
  endtask

  task automatic idle(input int d);
    wb_stb[d] = 1'b0;
    wb_cyc[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs(input int d);
    chk("reset_outputs", {wb_rdat[d], wb_ack[d], wb_err[d], mem_en[d], mem_we[d],
                          mem_be[d], mem_addr[d], mem_wdata[d]}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, r0;
    for (int d = 0; d < N; d++) begin
      rst_n[d] = 1'b0; wb_adr[d] = '0; wb_wdat[d] = '0; wb_we[d] = 1'b0;
      wb_sel[d] = '0; wb_stb[d] = 1'b0; wb_cyc[d] = 1'b0;
      en_cnt[d] = 0; resp_cnt[d] = 0; exp_dat[d] = 32'h0;
      for (int a = 0; a < 64; a++) sram[d][a] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) check_reset_outs(d);
    for (int d = 0; d < N; d++) rst_n[d] = 1'b1;
    @(posedge clk); #1;

    // ---- WAIT_STATES=0 ----
    e0 = en_cnt[0];
    xfer(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0); idle(0);
    chk("w0_en_cycles", en_cnt[0] - e0, 1);
    chk("w0_mem_addr", last_addr[0], 12'h4);
    chk("w0_mem_we", last_we[0], 1);
    chk("w0_mem_be", last_be[0], 4'hF);
    chk("w0_mem_wdata", last_wdat[0], 32'hDEAD_BEEF);
    xfer(0, 0, 32'h10, 0, 4'hF, 32'hDEAD_BEEF, 0); idle(0);
    xfer(0, 1, 32'h10, 32'h0, 4'h0, 0, 0); idle(0);
    chk("sel0_mem_be", last_be[0], 4'h0);
    xfer(0, 1, 32'h13, 32'h1234_5678, 4'b0101, 0, 0); idle(0);
    xfer(0, 0, 32'h11, 0, 4'hF, 32'hDE34_BE78, 0); idle(0);
    e0 = en_cnt[0];
    xfer(0, 0, 32'h0001_0000, 0, 4'hF, 0, 1); idle(0);
    chk("err_no_mem_en", en_cnt[0] - e0, 0);

    // ---- WAIT_STATES=3 ----
    xfer(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0); idle(1);
    xfer(1, 0, 32'h10, 0, 4'hF, 32'hDEAD_BEEF, 0); idle(1);
    xfer(1, 1, 32'h20, 32'hA0A0_0020, 4'hF, 0, 0); idle(1);
    xfer(1, 1, 32'h24, 32'hA0A0_0024, 4'hF, 0, 0); idle(1);
    xfer(1, 1, 32'h28, 32'hA0A0_0028, 4'hF, 0, 0); idle(1);
    // stb held across three reads: each starts the cycle after the previous ack
    xfer(1, 0, 32'h20, 0, 4'hF, 32'hA0A0_0020, 0);
    xfer(1, 0, 32'h24, 0, 4'hF, 32'hA0A0_0024, 0);
    xfer(1, 0, 32'h28, 0, 4'hF, 32'hA0A0_0028, 0);
    xfer(1, 0, 32'hFFFF_0000, 0, 4'hF, 0, 1); idle(1);

    // ---- WAIT_STATES=2: abort in WAIT ----
    xfer(2, 1, 32'h30, 32'h0000_0055, 4'hF, 0, 0); idle(2);
    r0 = resp_cnt[2];
    wb_adr[2] = 32'h30; wb_we[2] = 1'b0; wb_stb[2] = 1'b1; wb_cyc[2] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    wb_cyc[2] = 1'b0; wb_stb[2] = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    chk("abort_no_resp", resp_cnt[2] - r0, 0);
    xfer(2, 1, 32'h34, 32'h0000_0066, 4'hF, 0, 0); idle(2);
    xfer(2, 0, 32'h30, 0, 4'hF, 32'h0000_0055, 0); idle(2);

    // ---- WAIT_STATES=2: reset in WAIT ----
    r0 = resp_cnt[2];
    wb_adr[2] = 32'h34; wb_we[2] = 1'b0; wb_stb[2] = 1'b1; wb_cyc[2] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n[2] = 1'b0;
    @(posedge clk); #1;
    check_reset_outs(2);
    exp_dat[2] = 32'h0;
    wb_stb[2] = 1'b0; wb_cyc[2] = 1'b0;
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk("reset_no_resp", resp_cnt[2] - r0, 0);
    chk("reset_dat_cleared", wb_rdat[2], 0);
    xfer(2, 0, 32'h34, 0, 4'hF, 32'h0000_0066, 0); idle(2);

    repeat (4) begin @(posedge clk); #1; end
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
